pipeline_hazard_ctrl: RTL

Central sequencer for the RAT pipeline registers (IF/ID, ID/EX control vector).
- Detects RAW hazards with a small in-flight-writer scoreboard and stalls decode.
- Flushes younger stages on a taken branch.
- Runs the interrupt entry sequence that drives the ID/EX register's nop and interrupt inputs.
- Sits beside the decoder; its outputs feed the PC enable, IF/ID enable/flush, and the ID/EX register's nop/interrupt pins.

---
 rtl/rat_pipe_pkg.sv | 27 ++
 rtl/hazard_scoreboard.sv | 56 +++++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rat_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rat_pipe_pkg
//  Description : Shared types for the RAT pipeline hazard controller:
//                interrupt FSM state encoding and scoreboard entry layout.
//  Revision    : 1.0  initial release
// ============================================================================
package rat_pipe_pkg;

   localparam int REG_ADDR_W = 5;

   // Interrupt entry sequence states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      INJECT = 2'd2,
      VECTOR = 2'd3
   } int_state_t;

   // One in-flight register-file writer
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
   } sb_entry_t;

endpackage : rat_pipe_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Shift register of in-flight register-file writers between
//                ID issue and write-back, with a two-port address match used
//                for RAW detection on the DX and DY source operands.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
   import rat_pipe_pkg::*;
#(
   parameter int SB_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   input  logic [REG_ADDR_W-1:0] load_addr,
   input  logic [REG_ADDR_W-1:0] src_x,
   input  logic [REG_ADDR_W-1:0] src_y,
   output logic                  match_x,
   output logic                  match_y,
   output logic                  empty
);

   sb_entry_t [SB_DEPTH-1:0] r_sb;
   logic      [SB_DEPTH-1:0] w_hit_x;
   logic      [SB_DEPTH-1:0] w_hit_y;
   logic      [SB_DEPTH-1:0] w_valid;

   // Age every writer by one slot per cycle; the oldest falls off at write-back
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sb <= '0;
      end else begin
         r_sb[0].valid <= load_valid;
         r_sb[0].addr  <= load_addr;
         for (int i = 1; i < SB_DEPTH; i++) begin
            r_sb[i] <= r_sb[i-1];
         end
      end
   end

   generate
      for (genvar g = 0; g < SB_DEPTH; g++) begin : g_match
         assign w_valid[g] = r_sb[g].valid;
         assign w_hit_x[g] = r_sb[g].valid & (r_sb[g].addr == src_x);
         assign w_hit_y[g] = r_sb[g].valid & (r_sb[g].addr == src_y);
      end
   endgenerate

   assign match_x = |w_hit_x;
   assign match_y = |w_hit_y;
   assign empty   = ~|w_valid;

endmodule : hazard_scoreboard
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central sequencer for the IF/ID and ID/EX pipeline registers.
//                Stalls decode on RAW hazards (no forwarding), flushes younger
//                stages after a taken branch and runs the interrupt entry
//                sequence (drain, inject, vector).
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
   import rat_pipe_pkg::*;
#(
   parameter int SB_DEPTH     = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic                  id_rf_wr,
   input  logic [REG_ADDR_W-1:0] id_wb_addr,
   input  logic                  id_uses_x,
   input  logic [REG_ADDR_W-1:0] id_src_x,
   input  logic                  id_uses_y,
   input  logic [REG_ADDR_W-1:0] id_src_y,
   input  logic                  ex_valid,
   input  logic                  ex_branch_taken,
   input  logic                  int_req,
   input  logic                  i_flag,
   output logic                  pc_stall,
   output logic                  ifid_stall,
   output logic                  ifid_flush,
   output logic                  idex_nop,
   output logic                  idex_interrupt,
   output logic                  int_ack,
   output logic                  int_busy
);

   localparam logic [1:0] c_flush_load = 2'(FLUSH_CYCLES);

   int_state_t r_state;
   int_state_t w_state_next;
   logic [1:0] r_flush_cnt;

   logic w_match_x;
   logic w_match_y;
   logic w_sb_empty;
   logic w_raw_stall;
   logic w_flush_active;
   logic w_issue;

   assign w_raw_stall    = id_valid & ((id_uses_x & w_match_x) | (id_uses_y & w_match_y));
   assign w_flush_active = (r_flush_cnt != 2'd0) | ex_branch_taken;
   // A writer only enters the scoreboard if it actually leaves ID this cycle
   assign w_issue        = ~w_raw_stall & ~w_flush_active & (r_state == IDLE);

   hazard_scoreboard #(
      .SB_DEPTH (SB_DEPTH)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .load_valid (id_valid & id_rf_wr & w_issue),
      .load_addr  (id_wb_addr),
      .src_x      (id_src_x),
      .src_y      (id_src_y),
      .match_x    (w_match_x),
      .match_y    (w_match_y),
      .empty      (w_sb_empty)
   );

   // Bubble counter: reloaded by any taken branch or by the interrupt inject
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush_cnt <= 2'd0;
      end else if (ex_branch_taken || (r_state == INJECT)) begin
         r_flush_cnt <= c_flush_load;
      end else if (r_flush_cnt != 2'd0) begin
         r_flush_cnt <= r_flush_cnt - 2'd1;
      end
   end

   // Interrupt FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Interrupt FSM next state; a pending flush holds off both entry and inject
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (int_req && i_flag && !w_flush_active) begin
               w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!int_req) begin
               w_state_next = IDLE;
            end else if (w_sb_empty && !ex_valid && !w_flush_active) begin
               w_state_next = INJECT;
            end
         end
         INJECT: begin
            w_state_next = VECTOR;
         end
         VECTOR: begin
            if (r_flush_cnt == 2'd0) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Pipeline control outputs in strict priority order
   always_comb begin
      pc_stall       = 1'b0;
      ifid_stall     = 1'b0;
      ifid_flush     = 1'b0;
      idex_nop       = 1'b0;
      idex_interrupt = 1'b0;
      int_ack        = 1'b0;
      if (w_flush_active) begin
         ifid_flush = 1'b1;
         idex_nop   = 1'b1;
      end else if (r_state == INJECT) begin
         idex_interrupt = 1'b1;
         int_ack        = 1'b1;
         pc_stall       = 1'b1;
         ifid_stall     = 1'b1;
      end else if ((r_state == DRAIN) || ((r_state == VECTOR) && (r_flush_cnt == 2'd0))) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_nop   = 1'b1;
      end else if (w_raw_stall) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_nop   = 1'b1;
      end
   end

   assign int_busy = (r_state != IDLE);

endmodule : pipeline_hazard_ctrl
`default_nettype wire
